magia_l2_mux: RTL and testbench
===============================

Name: magia_l2_mux

Overview:
- Concentrates the N_TILES_Y per-row L2 request/response channels leaving the mesh into a single in-order L2 memory port.
- Sits directly downstream of the mesh's row-edge L2 NoC ports (after protocol unpacking) and upstream of the L2 memory / memory VIP.
- Round-robin arbitration with a one-entry registered request stage.
- An ordered route FIFO steers each memory response back to the issuing row.

Parameters:
- N_PORTS, 4: number of upstream request ports; equals N_TILES_Y.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; BE width is DATA_W/8.
- MAX_OUTST, 8: maximum transactions in flight (buffered plus issued, not yet responded); power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  N_PORTS  per-port request valid.
- req_ready_o  out  N_PORTS  per-port grant/accept.
- req_addr_i  in  N_PORTS*ADDR_W  per-port address.
- req_we_i  in  N_PORTS  per-port write enable.
- req_wdata_i  in  N_PORTS*DATA_W  per-port write data.
- req_be_i  in  N_PORTS*DATA_W/8  per-port byte enables.
- rsp_valid_o  out  N_PORTS  per-port response valid.
- rsp_ready_i  in  N_PORTS  per-port response ready.
- rsp_rdata_o  out  DATA_W  response data, shared by all ports, qualified by rsp_valid_o.
- rsp_err_o  out  1  response error, shared, qualified by rsp_valid_o.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory request ready.
- mem_addr_o  out  ADDR_W  memory address.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_be_o  out  DATA_W/8  memory byte enables.
- mem_rsp_valid_i  in  1  memory response valid; responses are strictly in order.
- mem_rsp_ready_o  out  1  memory response ready.
- mem_rsp_rdata_i  in  DATA_W  memory response data.
- mem_rsp_err_i  in  1  memory response error.
- outst_o  out  $clog2(MAX_OUTST)+1  current in-flight count.
- spurious_o  out  1  sticky flag: a memory response arrived with no transaction in flight.

Behaviour:
- Reset (rst_i sampled high at a clock edge) clears:
  - request buffer (mem_req_valid_o=0);
  - route FIFO (empty), outst_o=0, spurious_o=0;
  - round-robin pointer to 0.
  - Reset takes priority over every other event in the same cycle.
  - In-flight transactions are dropped. Memory responses arriving after reset with the FIFO empty set spurious_o; the bench must drain memory before reset.
- Upstream protocol: valid/ready. Addr, we, wdata and be must be held stable while valid && !ready.
- Request buffer: one entry driving mem_*_o.
  - can_accept = (!mem_req_valid_o || mem_req_ready_i) && outst_o < MAX_OUTST.
- Arbitration:
  - When can_accept, grant the first requesting port at or after rr_ptr (cyclic search).
  - req_ready_o is one-hot on the granted port; all ports are 0 if there is no grant.
  - req_ready_o depends combinationally on req_valid_i, rr_ptr, mem_req_ready_i and outst_o.
- On grant:
  - the buffer loads the granted port's fields next edge, mem_req_valid_o=1;
  - the port index is pushed to the route FIFO;
  - rr_ptr <= (granted+1) mod N_PORTS.
  - rr_ptr is unchanged when there is no grant.
- Latency: request accepted in cycle t appears on mem_* in cycle t+1. Back-to-back throughput is 1 per cycle when mem_req_ready_i=1.
- Buffer hold: while mem_req_valid_o && !mem_req_ready_i, mem_* outputs are stable.
- Response routing (combinational):
  - head = FIFO head.
  - rsp_valid_o[head] = mem_rsp_valid_i && !fifo_empty; all other bits are 0.
  - rsp_rdata_o / rsp_err_o = mem_rsp_rdata_i / mem_rsp_err_i.
  - mem_rsp_ready_o = fifo_empty ? 1 : rsp_ready_i[head].
  - Response handshake (mem_rsp_valid_i && mem_rsp_ready_o && !fifo_empty) pops the FIFO.
- Spurious response: mem_rsp_valid_i=1 while the FIFO is empty is accepted and discarded, and sets spurious_o=1 until reset.
- Counter:
  - outst_o = FIFO occupancy: +1 on grant, -1 on pop, unchanged when both happen in the same cycle.
  - A pop in the same cycle does NOT free a slot for a grant, because can_accept uses the registered outst_o.
  - outst_o never exceeds MAX_OUTST and never underflows.
- Boundaries:
  - FIFO pointers wrap modulo MAX_OUTST.
  - Full FIFO: all req_ready_o=0.
  - The buffered request counts toward outst_o from its grant.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with random inputs → req_ready_o=0, mem_req_valid_o=0, rsp_valid_o=0, outst_o=0, spurious_o=0; mem_rsp_ready_o=1.
- Single read: port 2 reads addr 0x1000, memory zero-latency ready, responds 0xDEADBEEF 3 cycles later → mem_addr_o=0x1000 one cycle after grant; rsp_valid_o=4'b0100 with rdata 0xDEADBEEF; outst_o returns 0.
- Round-robin fairness: all 4 ports valid continuously, 3 requests each → grant order 0,1,2,3,0,1,2,3,0,1,2,3; responses routed in that order.
- Outstanding limit: MAX_OUTST=8, memory accepts but never responds → exactly 8 grants, then req_ready_o=0 and outst_o=8. Release one response → exactly one further grant, not earlier than the cycle after the pop.
- Backpressure:
  - mem_req_ready_i=0 for 5 cycles with a buffered write (addr 0x20, wdata 0xA5A5A5A5, be 4'hF) → mem_* stable for all 5 cycles, no further grants.
  - Head port rsp_ready_i=0 → mem_rsp_ready_o=0 and the FIFO is not popped.
- Spurious response and mid-operation reset:
  - mem_rsp_valid_i=1 with the FIFO empty → spurious_o=1 next cycle and stays 1.
  - Reset asserted with 3 in flight → outst_o=0 and spurious_o=0 the cycle after reset.

Source files
------------

// File: rtl/magia_l2_mux.sv
// Concentrates N_PORTS row-edge L2 request channels into one in-order memory port.
// Round-robin arbitration, one registered request stage, and a route FIFO that steers responses home.
module magia_l2_mux #(
  parameter int N_PORTS   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_PORTS-1:0]            req_valid_i,
  output logic [N_PORTS-1:0]            req_ready_o,
  input  logic [N_PORTS*ADDR_W-1:0]     req_addr_i,
  input  logic [N_PORTS-1:0]            req_we_i,
  input  logic [N_PORTS*DATA_W-1:0]     req_wdata_i,
  input  logic [N_PORTS*DATA_W/8-1:0]   req_be_i,
  output logic [N_PORTS-1:0]            rsp_valid_o,
  input  logic [N_PORTS-1:0]            rsp_ready_i,
  output logic [DATA_W-1:0]             rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic [DATA_W/8-1:0]           mem_be_o,
  input  logic                          mem_rsp_valid_i,
  output logic                          mem_rsp_ready_o,
  input  logic [DATA_W-1:0]             mem_rsp_rdata_i,
  input  logic                          mem_rsp_err_i,
  output logic [$clog2(MAX_OUTST):0]    outst_o,
  output logic                          spurious_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic              buf_we_q, buf_we_d;
  logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
  logic [BE_W-1:0]   buf_be_q, buf_be_d;
  logic [IDX_W-1:0]  fifo_q [MAX_OUTST];
  logic [IDX_W-1:0]  fifo_d [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              spurious_q, spurious_d;

  logic              can_accept;
  logic              grant;
  logic [IDX_W-1:0]  gnt_idx;
  logic              fifo_empty;
  logic [IDX_W-1:0]  head;
  logic              pop;

  // Grant is suppressed during reset so no upstream handshake is lost to the clear.
  always_comb begin
    int idx;
    idx        = 0;
    can_accept = !rst_i && (!buf_valid_q || mem_req_ready_i) && (cnt_q < MAX_CNT);
    grant      = 1'b0;
    gnt_idx    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(rr_q) + i) % N_PORTS;
      if (can_accept && !grant && req_valid_i[idx]) begin
        grant   = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
    req_ready_o = '0;
    if (grant) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    fifo_empty  = (cnt_q == '0);
    head        = fifo_q[rd_ptr_q];
    pop         = mem_rsp_valid_i && !fifo_empty && rsp_ready_i[head];
    rsp_valid_o = '0;
    if (mem_rsp_valid_i && !fifo_empty) rsp_valid_o[head] = 1'b1;
    mem_rsp_ready_o = fifo_empty ? 1'b1 : rsp_ready_i[head];
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_we_d    = buf_we_q;
    buf_wdata_d = buf_wdata_q;
    buf_be_d    = buf_be_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    spurious_d  = spurious_q || (mem_rsp_valid_i && fifo_empty);
    if (buf_valid_q && mem_req_ready_i) buf_valid_d = 1'b0;
    if (grant) begin
      buf_valid_d      = 1'b1;
      buf_addr_d       = req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
      buf_we_d         = req_we_i[gnt_idx];
      buf_wdata_d      = req_wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
      buf_be_d         = req_be_i[int'(gnt_idx)*BE_W +: BE_W];
      fifo_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      rr_d             = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_we_q    <= 1'b0;
      buf_wdata_q <= '0;
      buf_be_q    <= '0;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      spurious_q  <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_we_q    <= buf_we_d;
      buf_wdata_q <= buf_wdata_d;
      buf_be_q    <= buf_be_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      spurious_q  <= spurious_d;
    end
  end

  assign mem_req_valid_o = buf_valid_q;
  assign mem_addr_o      = buf_addr_q;
  assign mem_we_o        = buf_we_q;
  assign mem_wdata_o     = buf_wdata_q;
  assign mem_be_o        = buf_be_q;
  assign rsp_rdata_o     = mem_rsp_rdata_i;
  assign rsp_err_o       = mem_rsp_err_i;
  assign outst_o         = cnt_q;
  assign spurious_o      = spurious_q;

endmodule

// File: tb/tb_magia_l2_mux.sv
// Directed self-checking bench for magia_l2_mux: reset, routing, round-robin, limits, backpressure.
module tb_magia_l2_mux;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i, req_ready_o, req_we_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N*BW-1:0] req_be_i;
  logic [N-1:0]    rsp_valid_o, rsp_ready_i;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic            mem_req_valid_o, mem_req_ready_i, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [BW-1:0]   mem_be_o;
  logic            mem_rsp_valid_i, mem_rsp_ready_o, mem_rsp_err_i;
  logic [DW-1:0]   mem_rsp_rdata_i;
  logic [3:0]      outst_o;
  logic            spurious_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  magia_l2_mux #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_rdata_i(mem_rsp_rdata_i), .mem_rsp_err_i(mem_rsp_err_i),
    .outst_o(outst_o), .spurious_o(spurious_o)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    req_valid_i     = '0;
    req_we_i        = '0;
    req_addr_i      = '0;
    req_wdata_i     = '0;
    req_be_i        = '0;
    rsp_ready_i     = '1;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_rdata_i = '0;
    mem_rsp_err_i   = 1'b0;
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    req_valid_i[p]         = v;
    req_we_i[p]            = we;
    req_addr_i[p*AW +: AW] = a;
    req_wdata_i[p*DW +: DW] = d;
    req_be_i[p*BW +: BW]   = be;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_i = 1'b1;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req_valid_i     = 4'($urandom);
      req_addr_i      = {$urandom, $urandom, $urandom, $urandom};
      req_we_i        = 4'($urandom);
      rsp_ready_i     = 4'($urandom);
      mem_req_ready_i = 1'($urandom_range(0, 1));
      mem_rsp_valid_i = 1'($urandom_range(0, 1));
      mem_rsp_rdata_i = $urandom;
      mem_rsp_err_i   = 1'b0;
      next_cycle();
    end
    @(negedge clk_i);
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", req_ready_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid got=%b exp=0", mem_req_valid_o); end
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0000", rsp_valid_o); end
    checks++; if (outst_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_outst got=%0d exp=0", outst_o); end
    checks++; if (spurious_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_spurious got=%b exp=0", spurious_o); end
    next_cycle();
    rst_i = 1'b0;
    drive_idle();
    @(negedge clk_i);
    checks++; if (mem_rsp_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_mem_rsp_ready got=%b exp=1", mem_rsp_ready_o); end
    checks++; if (outst_o !== 4'd0 || mem_req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle outst=%0d mem_valid=%b exp 0/0", outst_o, mem_req_valid_o); end
    next_cycle();
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(2, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF);
    @(negedge clk_i);
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant got=%b exp=0100", req_ready_o); end
    next_cycle();
    req_valid_i = '0;
    @(negedge clk_i);
    checks++; if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h1000 || mem_we_o !== 1'b0)
      begin errors++; $display("[TB] FAIL single_mem_req valid=%b addr=%h we=%b exp 1/00001000/0", mem_req_valid_o, mem_addr_o, mem_we_o); end
    checks++; if (outst_o !== 4'd1) begin errors++; $display("[TB] FAIL single_outst got=%0d exp=1", outst_o); end
    next_cycle();
    @(negedge clk_i);
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_mem_drained got=%b exp=0", mem_req_valid_o); end
    next_cycle();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 4'b0100 || rsp_rdata_o !== 32'hDEADBEEF || mem_rsp_ready_o !== 1'b1)
      begin errors++; $display("[TB] FAIL single_rsp valid=%b rdata=%h ready=%b exp 0100/deadbeef/1", rsp_valid_o, rsp_rdata_o, mem_rsp_ready_o); end
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (outst_o !== 4'd0 || rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL single_done outst=%0d rsp_valid=%b exp 0/0000", outst_o, rsp_valid_o); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int sent[N];
    int grants, resps, issued;
    logic [31:0] q[$];
    logic [31:0] exp_addr;
    do_reset();
    grants = 0; resps = 0; issued = 0;
    for (int p = 0; p < N; p++) sent[p] = 0;
    for (int cyc = 0; cyc < 80 && resps < 12; cyc++) begin
      for (int p = 0; p < N; p++) set_req(p, sent[p] < 3, 1'b0, 32'((p << 8) | sent[p]), 32'h0, 4'hF);
      mem_rsp_valid_i = (q.size() > 0);
      mem_rsp_rdata_i = (q.size() > 0) ? ~q[0] : 32'h0;
      @(negedge clk_i);
      if (req_ready_o != 4'b0000) begin
        checks++; if (req_ready_o !== 4'(1 << (grants % 4))) begin errors++; $display("[TB] FAIL rr_grant_%0d got=%b exp=%b", grants, req_ready_o, 4'(1 << (grants % 4))); end
        for (int p = 0; p < N; p++) if (req_ready_o[p]) sent[p]++;
        grants++;
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        exp_addr = 32'(((issued % 4) << 8) | (issued / 4));
        checks++; if (mem_addr_o !== exp_addr) begin errors++; $display("[TB] FAIL rr_mem_addr_%0d got=%h exp=%h", issued, mem_addr_o, exp_addr); end
        q.push_back(mem_addr_o);
        issued++;
      end
      if (mem_rsp_valid_i) begin
        checks++; if (rsp_valid_o !== 4'(1 << (resps % 4)) || rsp_rdata_o !== mem_rsp_rdata_i)
          begin errors++; $display("[TB] FAIL rr_rsp_%0d valid=%b exp=%b", resps, rsp_valid_o, 4'(1 << (resps % 4))); end
        if (mem_rsp_ready_o) begin
          void'(q.pop_front());
          resps++;
        end
      end
      next_cycle();
    end
    drive_idle();
    @(negedge clk_i);
    checks++; if (grants != 12 || resps != 12) begin errors++; $display("[TB] FAIL rr_counts grants=%0d resps=%0d exp 12/12", grants, resps); end
    checks++; if (outst_o !== 4'd0) begin errors++; $display("[TB] FAIL rr_outst got=%0d exp=0", outst_o); end
    next_cycle();
  endtask

  task automatic test_outst_limit();
    int grants;
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (req_ready_o != 4'b0000) grants++;
      next_cycle();
    end
    @(negedge clk_i);
    checks++; if (grants != 8) begin errors++; $display("[TB] FAIL limit_grants got=%0d exp=8", grants); end
    checks++; if (req_ready_o !== 4'b0000 || outst_o !== 4'd8) begin errors++; $display("[TB] FAIL limit_full ready=%b outst=%0d exp 0000/8", req_ready_o, outst_o); end
    next_cycle();
    mem_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL limit_pop_same_cycle ready=%b exp=0000", req_ready_o); end
    checks++; if (rsp_valid_o !== 4'b0001) begin errors++; $display("[TB] FAIL limit_rsp_route got=%b exp=0001", rsp_valid_o); end
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        checks++; if (req_ready_o !== 4'b0001 || outst_o !== 4'd7) begin errors++; $display("[TB] FAIL limit_regrant ready=%b outst=%0d exp 0001/7", req_ready_o, outst_o); end
      end
      if (req_ready_o != 4'b0000) grants++;
      next_cycle();
    end
    @(negedge clk_i);
    checks++; if (grants != 1 || outst_o !== 4'd8) begin errors++; $display("[TB] FAIL limit_one_more grants=%0d outst=%0d exp 1/8", grants, outst_o); end
    next_cycle();
    req_valid_i     = '0;
    mem_rsp_valid_i = 1'b1;
    repeat (8) next_cycle();
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (outst_o !== 4'd0 || spurious_o !== 1'b0) begin errors++; $display("[TB] FAIL limit_drain outst=%0d spurious=%b exp 0/0", outst_o, spurious_o); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_req_ready_i = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
    set_req(3, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    @(negedge clk_i);
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL bp_first_grant got=%b exp=0010", req_ready_o); end
    next_cycle();
    req_valid_i[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      checks++; if ({mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== {1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF} || req_ready_o !== 4'b0000)
        begin errors++; $display("[TB] FAIL bp_hold_%0d valid=%b we=%b addr=%h wdata=%h be=%h ready=%b exp 1/1/20/a5a5a5a5/f/0000", c, mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, req_ready_o); end
      next_cycle();
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("[TB] FAIL bp_release_grant got=%b exp=1000", req_ready_o); end
    next_cycle();
    req_valid_i[3] = 1'b0;
    @(negedge clk_i);
    checks++; if (mem_addr_o !== 32'h30 || outst_o !== 4'd2) begin errors++; $display("[TB] FAIL bp_second_req addr=%h outst=%0d exp 30/2", mem_addr_o, outst_o); end
    next_cycle();
    rsp_ready_i     = 4'b1101;
    mem_rsp_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++; if (mem_rsp_ready_o !== 1'b0 || rsp_valid_o !== 4'b0010) begin errors++; $display("[TB] FAIL bp_rsp_stall_%0d ready=%b valid=%b exp 0/0010", c, mem_rsp_ready_o, rsp_valid_o); end
      next_cycle();
    end
    rsp_ready_i = 4'b1111;
    @(negedge clk_i);
    checks++; if (outst_o !== 4'd2 || rsp_valid_o !== 4'b0010) begin errors++; $display("[TB] FAIL bp_no_pop outst=%0d valid=%b exp 2/0010", outst_o, rsp_valid_o); end
    next_cycle();
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 4'b1000) begin errors++; $display("[TB] FAIL bp_second_rsp got=%b exp=1000", rsp_valid_o); end
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (outst_o !== 4'd0) begin errors++; $display("[TB] FAIL bp_drain outst=%0d exp=0", outst_o); end
    next_cycle();
  endtask

  task automatic test_spurious_reset();
    logic [N-1:0] granted;
    drive_idle();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_rdata_i = 32'h55;
    @(negedge clk_i);
    checks++; if (mem_rsp_ready_o !== 1'b1 || rsp_valid_o !== 4'b0000 || spurious_o !== 1'b0)
      begin errors++; $display("[TB] FAIL spur_accept ready=%b valid=%b spurious=%b exp 1/0000/0", mem_rsp_ready_o, rsp_valid_o, spurious_o); end
    next_cycle();
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (spurious_o !== 1'b1) begin errors++; $display("[TB] FAIL spur_set got=%b exp=1", spurious_o); end
    repeat (3) next_cycle();
    @(negedge clk_i);
    checks++; if (spurious_o !== 1'b1) begin errors++; $display("[TB] FAIL spur_sticky got=%b exp=1", spurious_o); end
    next_cycle();
    for (int p = 0; p < 3; p++) set_req(p, 1'b1, 1'b0, 32'(32'h40 + p), 32'h0, 4'hF);
    granted = '0;
    for (int c = 0; c < 10 && granted != 4'b0111; c++) begin
      @(negedge clk_i);
      granted = granted | req_ready_o;
      next_cycle();
      req_valid_i = req_valid_i & ~granted;
    end
    next_cycle();
    @(negedge clk_i);
    checks++; if (outst_o !== 4'd3) begin errors++; $display("[TB] FAIL spur_inflight outst=%0d exp=3", outst_o); end
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (outst_o !== 4'd0 || spurious_o !== 1'b0 || mem_req_valid_o !== 1'b0)
      begin errors++; $display("[TB] FAIL spur_midreset outst=%0d spurious=%b mem_valid=%b exp 0/0/0", outst_o, spurious_o, mem_req_valid_o); end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    drive_idle();
    rst_i = 1'b0;
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_outst_limit();
    test_backpressure();
    test_spurious_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
